// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: load/store front end for the word-addressed data memory; partial stores run as read-modify-write.
// Build option MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of forcing natural alignment.
module dm_access_ctrl #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_sext,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_din,
  output logic              dm_we,
  input  logic [31:0]       dm_dout
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t      state;
  logic        l_wr;
  logic [1:0]  l_size;
  logic        l_sext;
  logic [1:0]  l_lane;
  logic [31:0] l_wdata;
  logic [31:0] rd_word;

  logic [31:0] offset;
  logic        out_of_window;
  logic        req_err;
  logic [1:0]  req_lane;

  function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] m;
    m = old;
    case (size)
      2'b00:   m[{lane, 3'b000} +: 8] = wd[7:0];
      2'b01:   m[{lane[1], 4'b0000} +: 16] = wd[15:0];
      default: m = wd;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] extract_load(input logic [31:0] w, input logic [1:0] size,
                                               input logic sext, input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   return {{24{sext & b[7]}}, b};
      2'b01:   return {{16{sext & h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // The memory index is taken from the window offset, so a non-zero base maps to word 0.
  assign offset        = req_addr - BASE_ADDR;
  assign out_of_window = |offset[31:ADDR_W+2];

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((req_size == 2'b01) && offset[0]) ||
                      ((req_size == 2'b10) && (offset[1:0] != 2'b00));
  assign req_err    = (req_size == 2'b11) || out_of_window || misaligned;
  assign req_lane   = offset[1:0];
`else
  assign req_err    = (req_size == 2'b11) || out_of_window;
  assign req_lane   = (req_size == 2'b01) ? {offset[1], 1'b0} :
                      (req_size == 2'b10) ? 2'b00 : offset[1:0];
`endif

  // Word stores fall through the default merge branch, so rd_word is irrelevant for them.
  assign dm_din = merge_word(rd_word, l_wdata, l_size, l_lane);

  // dm_we is its own flop, set exactly when the next state is WRITE, so it cannot glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= '0;
      l_wr      <= 1'b0;
      l_size    <= 2'b00;
      l_sext    <= 1'b0;
      l_lane    <= 2'b00;
      l_wdata   <= 32'h0;
      rd_word   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            l_wr      <= req_wr;
            l_size    <= req_size;
            l_sext    <= req_sext;
            l_lane    <= req_lane;
            l_wdata   <= req_wdata;
            dm_addr   <= offset[ADDR_W+1:2];
            req_ready <= 1'b0;
            if (req_err) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'h0;
            end else if (!req_wr || (req_size != 2'b10)) begin
              state <= READ;
            end else begin
              state <= WRITE;
              dm_we <= 1'b1;
            end
          end
        end
        READ: begin
          rd_word <= dm_dout;
          if (l_wr) begin
            state <= WRITE;
            dm_we <= 1'b1;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= extract_load(dm_dout, l_size, l_sext, l_lane);
          end
        end
        WRITE: begin
          dm_we     <= 1'b0;
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'h0;
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'h0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: directed cases plus random traffic against a word-array reference model.
module tb_dm_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_sext;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [9:0]  dm_addr;
  logic [31:0] dm_din;
  logic        dm_we;
  logic [31:0] dm_dout;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];
  bit          mem_loaded = 0;

  int nChecks = 0;
  int nPass   = 0;

  dm_access_ctrl #(.ADDR_W(10), .BASE_ADDR(32'h0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_size  (req_size),
    .req_sext  (req_sext),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .dm_addr   (dm_addr),
    .dm_din    (dm_din),
    .dm_we     (dm_we),
    .dm_dout   (dm_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: combinational read, write sampled on the falling edge; loaded from the reference copy once.
  assign dm_dout = mem[dm_addr];
  always @(negedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 1024; i++) mem[i] = ref_mem[i];
      mem_loaded = 1;
    end else if (dm_we) begin
      mem[dm_addr] = dm_din;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
  endtask

  // Reference behaviour from the access rules: byte offsets, masks and shifts on a word array.
  task automatic modelAccess(input logic wr, input logic [1:0] size, input logic sext,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic err, output logic [31:0] rdata,
                             output int lat, output int we, output int idx);
    logic [31:0] a, mask, v;
    int sh;
    a   = addr;
    err = (size == 2'b11) || (a >= 32'h1000);
`ifdef MISALIGN_TRAP_EN
    if ((size == 2'b01 && a[0]) || (size == 2'b10 && a[1:0] != 2'b00)) err = 1'b1;
`else
    if (size == 2'b01) a = a & ~32'h1;
    else if (size == 2'b10) a = a & ~32'h3;
`endif
    idx   = int'(a[11:2]);
    sh    = 8 * int'(a % 4);
    rdata = 32'h0;
    if (err) begin
      lat = 1; we = 0;
    end else if (wr) begin
      we  = 1;
      lat = (size == 2'b10) ? 2 : 3;
      if (size == 2'b10) ref_mem[idx] = wdata;
      else begin
        mask = ((size == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
        ref_mem[idx] = (ref_mem[idx] & ~mask) | ((wdata << sh) & mask);
      end
    end else begin
      lat = 2; we = 0;
      v = ref_mem[idx] >> sh;
      if (size == 2'b00) begin
        v = v & 32'hFF;
        if (sext && v[7]) v = v | 32'hFFFF_FF00;
      end else if (size == 2'b01) begin
        v = v & 32'hFFFF;
        if (sext && v[15]) v = v | 32'hFFFF_0000;
      end else v = ref_mem[idx];
      rdata = v;
    end
  endtask

  // Issue one request, wait for its response and compare it with the model; hold keeps req_valid high afterwards.
  task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic sext,
                               input logic [31:0] addr, input logic [31:0] wdata, input bit hold);
    logic        e, rdy, gotv, goterr;
    logic [31:0] er, gotd;
    int          elat, ewe, eidx, lat, wecnt, waitc;
    req_valid = 1'b1;
    req_wr    = wr;
    req_size  = size;
    req_sext  = sext;
    req_addr  = addr;
    req_wdata = wdata;
    rdy = 1'b0; waitc = 0;
    while (!rdy && waitc < 20) begin
      @(negedge clk); rdy = req_ready;
      @(posedge clk); #1;
      waitc++;
    end
    checkOutput("accept", 32'(rdy), 32'd1);
    if (!hold) req_valid = 1'b0;
    modelAccess(wr, size, sext, addr, wdata, e, er, elat, ewe, eidx);
    lat = 0; wecnt = 0; gotv = 1'b0; goterr = 1'b0; gotd = 32'h0;
    while (!gotv && lat < 10) begin
      @(negedge clk);
      lat++;
      if (dm_we) wecnt++;
      gotv = rsp_valid; goterr = rsp_err; gotd = rsp_rdata;
      @(posedge clk); #1;
    end
    checkOutput("latency", 32'(lat), 32'(elat));
    checkOutput("rsp_err", 32'(goterr), 32'(e));
    checkOutput("rsp_rdata", gotd, er);
    checkOutput("we_cycles", 32'(wecnt), 32'(ewe));
    if (!e && wr) checkOutput("mem_word", mem[eidx], ref_mem[eidx]);
  endtask

  initial begin
    logic [1:0]  rs;
    logic [31:0] ra;
    logic        rdy, seen;
    int          waitc, mism, k;

    for (int i = 0; i < 1024; i++) ref_mem[i] = $urandom;
    rst_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00;
    req_sext = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;

    #12;
    checkOutput("rst_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_we", 32'(dm_we), 32'd0);
    checkOutput("rst_dm_addr", 32'(dm_addr), 32'd0);
    checkOutput("rst_rdata", rsp_rdata, 32'd0);
    checkOutput("rst_err", 32'(rsp_err), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed word/byte/half accesses");
    applyStimulus(1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 0);
    applyStimulus(0, 2'b10, 0, 32'h10, 32'h0, 0);
    applyStimulus(1, 2'b10, 0, 32'h10, 32'h1122_3344, 0);
    applyStimulus(1, 2'b00, 0, 32'h12, 32'hFFFF_FFA5, 0);
    applyStimulus(0, 2'b00, 1, 32'h12, 32'h0, 0);
    applyStimulus(0, 2'b00, 0, 32'h12, 32'h0, 0);
    applyStimulus(1, 2'b10, 0, 32'h14, 32'h0, 0);
    applyStimulus(1, 2'b01, 0, 32'h16, 32'h1234_8001, 0);
    applyStimulus(0, 2'b01, 1, 32'h16, 32'h0, 0);
    applyStimulus(0, 2'b01, 0, 32'h16, 32'h0, 0);

    $display("[TB] misaligned, out-of-window and illegal size");
    applyStimulus(0, 2'b10, 0, 32'h13, 32'h0, 0);
    applyStimulus(1, 2'b01, 0, 32'h19, 32'hCAFE_F00D, 0);
    applyStimulus(0, 2'b10, 0, 32'h1000, 32'h0, 0);
    applyStimulus(1, 2'b10, 0, 32'h1000, 32'h5555_AAAA, 0);
    applyStimulus(0, 2'b11, 0, 32'h10, 32'h0, 0);
    applyStimulus(1, 2'b11, 0, 32'h10, 32'h7777_7777, 0);
    applyStimulus(0, 2'b10, 0, 32'h0FFC, 32'h0, 0);

    $display("[TB] back-to-back stores with req_valid held");
    applyStimulus(1, 2'b10, 0, 32'h20, 32'h0102_0304, 1);
    applyStimulus(1, 2'b00, 0, 32'h21, 32'h0000_00EE, 1);
    applyStimulus(1, 2'b01, 0, 32'h22, 32'h0000_BBCC, 0);
    applyStimulus(0, 2'b10, 0, 32'h20, 32'h0, 0);

    $display("[TB] reset during partial-store read");
    req_valid = 1'b1; req_wr = 1'b1; req_size = 2'b00; req_sext = 1'b0;
    req_addr = 32'h25; req_wdata = 32'h0000_005A;
    rdy = 1'b0; waitc = 0;
    while (!rdy && waitc < 20) begin
      @(negedge clk); rdy = req_ready;
      @(posedge clk); #1;
      waitc++;
    end
    checkOutput("rst_mid_accept", 32'(rdy), 32'd1);
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_mid_we", 32'(dm_we), 32'd0);
    @(negedge clk); #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (c == 0) checkOutput("rst_mid_idle", 32'(req_ready), 32'd1);
      if (rsp_valid || dm_we) seen = 1'b1;
    end
    checkOutput("rst_mid_no_rsp", 32'(seen), 32'd0);
    checkOutput("rst_mid_mem", mem[9], ref_mem[9]);
    @(posedge clk); #1;

    $display("[TB] random traffic");
    for (int n = 0; n < 300; n++) begin
      k  = int'($urandom_range(0, 19));
      rs = ($urandom_range(0, 19) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      if (k == 0) ra = 32'h1000 + $urandom_range(0, 255);
      else if (k == 1) ra = $urandom;
      else ra = $urandom_range(0, 127);
      applyStimulus(1'($urandom_range(0, 1)), rs, 1'($urandom_range(0, 1)), ra, $urandom,
                    (n != 299) && ($urandom_range(0, 3) == 0));
    end

    mism = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) mism++;
    checkOutput("mem_final", 32'(mism), 32'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
